id_hazard_ctrl: RTL and testbench
=================================

// Module: id_hazard_ctrl
// PURPOSE
//  ID-stage sequencer between fetch and the immediate generator/decoder.
//  - Owns the IF->ID pipeline register (inst, pc).
//  - Presents the held instruction to the immediate generator and to EX.
//  - Inserts load-use bubbles, serialises CSR instructions, squashes on redirect.
//  - Uses valid/ready handshakes on both sides.
// PARAMETERS
//  INST_WIDTH    32  instruction and PC width
//  CSR_DRAIN     2   cycles a CSR instr is held before issue (range 1..7)
// PORTS
//  clk            in   1           core clock, rising edge
//  rst            in   1           asynchronous, active-high reset
//  flush          in   1           redirect from EX; squash ID contents
//  if_valid       in   1           fetch presents an instruction
//  if_inst        in   INST_WIDTH  fetched instruction
//  if_pc          in   INST_WIDTH  PC of if_inst
//  id_ready       out  1           ID can accept from IF this cycle
//  id_valid       out  1           id_inst/id_pc are valid toward EX
//  id_inst        out  INST_WIDTH  held instruction (feeds immediate generator)
//  id_pc          out  INST_WIDTH  PC of held instruction
//  ex_ready       in   1           EX accepts the ID instruction
//  ex_load_valid  in   1           instruction in EX is a load
//  ex_load_rd     in   5           rd of that load
//  ld_use_stall   out  1           bubble being inserted this cycle
// BEHAVIOUR
//  Reset: async on rst high.
//  - state=EMPTY; id_valid=0; id_inst=0; id_pc=0; ld_use_stall=0; drain counter=0.
//  FSM states: EMPTY, HOLD, BUBBLE, CSR_WAIT.
//  Transfers (decided at the clk edge):
//  - IF->ID: if_valid && id_ready.
//  - ID->EX: id_valid && ex_ready.
//  id_ready (combinational) = !flush && (state==EMPTY || (id_valid && ex_ready)).
//  Source registers used (opcode[6:2]):
//  - rs1: R-type, I-arith, LOAD, STORE, BRANCH, JALR; also CSR when funct3[2]==0.
//  - rs2: R-type, STORE, BRANCH.
//  - LUI, AUIPC, JAL: none.
//  hazard = ex_load_valid && ex_load_rd!=0 && (used rs1==rd || used rs2==rd).
//  Transitions:
//  - EMPTY: on IF->ID transfer, latch inst/pc; go to CSR_WAIT if CSR opcode, else HOLD.
//  - HOLD: id_valid = !hazard. If hazard: ld_use_stall=1, go to BUBBLE.
//    On ID->EX transfer with a new IF->ID transfer in the same edge, reload
//    (CSR_WAIT if CSR); with no new transfer, go to EMPTY.
//  - BUBBLE: id_valid=0 for exactly one cycle, then HOLD; inst/pc unchanged.
//  - CSR_WAIT: id_valid=0; counter loads CSR_DRAIN on entry and decrements each
//    cycle; at 0 go to HOLD. The hazard check applies in HOLD as normal.
//  Latency: non-hazard instruction goes IF->ID edge to id_valid=1 in the next cycle (1 cycle).
//  Back-to-back instructions issue at one per cycle while ex_ready=1.
//  ex_ready=0 in HOLD: hold inst/pc stable; id_valid stays 1.
//  flush: highest priority over every other event, including a simultaneous transfer.
//  - Next edge: state=EMPTY, id_valid=0, counter=0.
//  - id_ready=0 during the flush cycle, so no new instruction is latched.
//  Reset mid-CSR_WAIT or mid-BUBBLE: go to EMPTY; the held instruction is discarded.
//  ld_use_stall is combinational and is 1 only in HOLD with hazard=1.
// CONFIGURATION
//  Macro: ID_CSR_SERIALIZE_EN
//  - Defined: CSR_WAIT state and drain counter are present, as described above.
//  - Undefined: CSR instructions follow the normal path (EMPTY->HOLD).
//    No counter logic; CSR_DRAIN is ignored.
// TESTING
//  1. rst pulse mid-HOLD, asynchronous and not aligned to clk
//     -> id_valid=0, id_inst=0, id_pc=0 immediately; id_ready=1 after rst falls.
//  2. Stream ADDI x1,x0,5 / ADDI x2,x0,6 with ex_ready=1
//     -> id_valid=1 every cycle from cycle 1; pc 0x0 then 0x4 at EX.
//  3. ex_load_valid=1, ex_load_rd=5; ID holds ADD x6,x5,x7
//     -> ld_use_stall=1 and id_valid=0 for 1 cycle, then the ADD issues.
//     Same case with rd=0 -> no stall.
//  4. CSRRW x1,mstatus,x2 with ID_CSR_SERIALIZE_EN and CSR_DRAIN=2
//     -> id_valid low 2 cycles, then high. Without the macro -> issues next cycle.
//  5. flush=1 in the same cycle as if_valid=1 and id_valid=1, ex_ready=1
//     -> id_ready=0; next cycle state=EMPTY, id_valid=0; the new instruction is not latched.
//  6. ex_ready=0 for 3 cycles in HOLD
//     -> id_inst/id_pc stable, id_ready=0; transfer occurs when ex_ready returns to 1.

Source files
------------

// File: rtl/id_hazard_ctrl.sv
// rtl/id_hazard_ctrl.sv - ID-stage sequencer: IF->ID register, load-use bubbles, CSR serialisation, flush
//
// Purpose:
//   Owns the IF->ID pipeline register (instruction and PC). It presents the held
//   instruction to the immediate generator/decoder and to EX. It inserts a one-cycle
//   bubble on a load-use hazard and squashes its contents on a redirect. When
//   ID_CSR_SERIALIZE_EN is defined, it holds CSR instructions for CSR_DRAIN cycles
//   before they may issue.
//
// Configuration macro:
//   ID_CSR_SERIALIZE_EN - defined: CSR_WAIT state and drain counter are built.
//                         undefined: CSR instructions take the normal EMPTY->HOLD path.
//
// Ports:
//   clk            in   1           core clock, rising edge
//   rst            in   1           asynchronous, active-high reset
//   flush          in   1           redirect from EX; squash ID contents
//   if_valid       in   1           fetch presents an instruction
//   if_inst        in   INST_WIDTH  fetched instruction
//   if_pc          in   INST_WIDTH  PC of if_inst
//   id_ready       out  1           ID can accept from IF this cycle
//   id_valid       out  1           id_inst/id_pc valid toward EX
//   id_inst        out  INST_WIDTH  held instruction
//   id_pc          out  INST_WIDTH  PC of held instruction
//   ex_ready       in   1           EX accepts the ID instruction
//   ex_load_valid  in   1           instruction in EX is a load
//   ex_load_rd     in   5           rd of that load
//   ld_use_stall   out  1           bubble being inserted this cycle

module id_hazard_ctrl #(
  parameter int INST_WIDTH = 32,
  parameter int CSR_DRAIN  = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  flush,
  input  logic                  if_valid,
  input  logic [INST_WIDTH-1:0] if_inst,
  input  logic [INST_WIDTH-1:0] if_pc,
  output logic                  id_ready,
  output logic                  id_valid,
  output logic [INST_WIDTH-1:0] id_inst,
  output logic [INST_WIDTH-1:0] id_pc,
  input  logic                  ex_ready,
  input  logic                  ex_load_valid,
  input  logic [4:0]            ex_load_rd,
  output logic                  ld_use_stall
);

  typedef enum logic [1:0] {
    S_EMPTY    = 2'd0,
    S_HOLD     = 2'd1,
    S_BUBBLE   = 2'd2,
    S_CSR_WAIT = 2'd3
  } state_t;

  localparam logic [4:0] OPC_LOAD   = 5'b00000;
  localparam logic [4:0] OPC_IARITH = 5'b00100;
  localparam logic [4:0] OPC_STORE  = 5'b01000;
  localparam logic [4:0] OPC_RTYPE  = 5'b01100;
  localparam logic [4:0] OPC_BRANCH = 5'b11000;
  localparam logic [4:0] OPC_JALR   = 5'b11001;
  localparam logic [4:0] OPC_SYSTEM = 5'b11100;

  state_t                r_state;
  logic [INST_WIDTH-1:0] r_inst;
  logic [INST_WIDTH-1:0] r_pc;
`ifdef ID_CSR_SERIALIZE_EN
  logic [2:0]            r_cnt;
  logic                  w_if_is_csr;
`endif

  logic [4:0] w_opc;
  logic [4:0] w_rs1;
  logic [4:0] w_rs2;
  logic       w_use_rs1;
  logic       w_use_rs2;
  logic       w_hazard;
  logic       w_id_valid;
  logic       w_id_ready;
  logic       w_if_xfer;
  logic       w_ex_xfer;

  assign w_opc = r_inst[6:2];
  assign w_rs1 = r_inst[19:15];
  assign w_rs2 = r_inst[24:20];

  // Source-register usage of the held instruction. LUI/AUIPC/JAL and anything
  // unrecognised read no registers, so they can never see a load-use hazard.
  always_comb begin
    w_use_rs1 = 1'b0;
    w_use_rs2 = 1'b0;
    case (w_opc)
      OPC_RTYPE, OPC_STORE, OPC_BRANCH: begin
        w_use_rs1 = 1'b1;
        w_use_rs2 = 1'b1;
      end
      OPC_IARITH, OPC_LOAD, OPC_JALR: begin
        w_use_rs1 = 1'b1;
      end
      // CSR immediate forms (funct3[2]=1) put a zimm in the rs1 field.
      OPC_SYSTEM: begin
        w_use_rs1 = ~r_inst[14];
      end
      default: begin
        w_use_rs1 = 1'b0;
        w_use_rs2 = 1'b0;
      end
    endcase
  end

  assign w_hazard = ex_load_valid && (ex_load_rd != 5'd0) &&
                    ((w_use_rs1 && (w_rs1 == ex_load_rd)) ||
                     (w_use_rs2 && (w_rs2 == ex_load_rd)));

  assign w_id_valid = (r_state == S_HOLD) && !w_hazard;
  assign w_id_ready = !flush && ((r_state == S_EMPTY) || (w_id_valid && ex_ready));
  assign w_if_xfer  = if_valid && w_id_ready;
  assign w_ex_xfer  = w_id_valid && ex_ready;

`ifdef ID_CSR_SERIALIZE_EN
  assign w_if_is_csr = (if_inst[6:2] == OPC_SYSTEM);
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_EMPTY;
      r_inst  <= '0;
      r_pc    <= '0;
`ifdef ID_CSR_SERIALIZE_EN
      r_cnt   <= 3'd0;
`endif
    end else if (flush) begin
      // Redirect beats everything; id_ready is already low so nothing new is latched.
      r_state <= S_EMPTY;
`ifdef ID_CSR_SERIALIZE_EN
      r_cnt   <= 3'd0;
`endif
    end else begin
      case (r_state)
        S_EMPTY: begin
          if (w_if_xfer) begin
            r_inst <= if_inst;
            r_pc   <= if_pc;
`ifdef ID_CSR_SERIALIZE_EN
            if (w_if_is_csr) begin
              r_state <= S_CSR_WAIT;
              r_cnt   <= 3'(CSR_DRAIN);
            end else begin
              r_state <= S_HOLD;
            end
`else
            r_state <= S_HOLD;
`endif
          end
        end
        S_HOLD: begin
          if (w_hazard) begin
            r_state <= S_BUBBLE;
          end else if (w_ex_xfer) begin
            // Reload in the same edge keeps back-to-back issue at one per cycle.
            if (w_if_xfer) begin
              r_inst <= if_inst;
              r_pc   <= if_pc;
`ifdef ID_CSR_SERIALIZE_EN
              if (w_if_is_csr) begin
                r_state <= S_CSR_WAIT;
                r_cnt   <= 3'(CSR_DRAIN);
              end else begin
                r_state <= S_HOLD;
              end
`else
              r_state <= S_HOLD;
`endif
            end else begin
              r_state <= S_EMPTY;
            end
          end
        end
        S_BUBBLE: begin
          r_state <= S_HOLD;
        end
`ifdef ID_CSR_SERIALIZE_EN
        S_CSR_WAIT: begin
          // The cycle the counter would reach zero is the last wait cycle.
          if (r_cnt <= 3'd1) begin
            r_cnt   <= 3'd0;
            r_state <= S_HOLD;
          end else begin
            r_cnt   <= r_cnt - 3'd1;
          end
        end
`endif
        default: begin
          r_state <= S_EMPTY;
        end
      endcase
    end
  end

  assign id_ready     = w_id_ready;
  assign id_valid     = w_id_valid;
  assign id_inst      = r_inst;
  assign id_pc        = r_pc;
  assign ld_use_stall = (r_state == S_HOLD) && w_hazard;

endmodule

// File: tb/tb_id_hazard_ctrl.sv
// tb/tb_id_hazard_ctrl.sv - directed self-checking bench for id_hazard_ctrl

module tb_id_hazard_ctrl;

  localparam logic [31:0] ADDI1 = 32'h00500093; // ADDI x1,x0,5
  localparam logic [31:0] ADDI2 = 32'h00600113; // ADDI x2,x0,6
  localparam logic [31:0] ADD6  = 32'h00728333; // ADD x6,x5,x7
  localparam logic [31:0] LUI5  = 32'h123452B7; // LUI x5,0x12345
  localparam logic [31:0] CSRRW = 32'h300110F3; // CSRRW x1,mstatus,x2

  logic        clk;
  logic        rst;
  logic        flush;
  logic        if_valid;
  logic [31:0] if_inst;
  logic [31:0] if_pc;
  logic        id_ready;
  logic        id_valid;
  logic [31:0] id_inst;
  logic [31:0] id_pc;
  logic        ex_ready;
  logic        ex_load_valid;
  logic [4:0]  ex_load_rd;
  logic        ld_use_stall;

  int checks;
  int failures;

  id_hazard_ctrl #(
    .INST_WIDTH(32),
    .CSR_DRAIN (2)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .flush        (flush),
    .if_valid     (if_valid),
    .if_inst      (if_inst),
    .if_pc        (if_pc),
    .id_ready     (id_ready),
    .id_valid     (id_valid),
    .id_inst      (id_inst),
    .id_pc        (id_pc),
    .ex_ready     (ex_ready),
    .ex_load_valid(ex_load_valid),
    .ex_load_rd   (ex_load_rd),
    .ld_use_stall (ld_use_stall)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present one instruction from fetch for a single edge (state must be EMPTY).
  task automatic latch(input logic [31:0] inst, input logic [31:0] pc);
    if_valid = 1'b1;
    if_inst  = inst;
    if_pc    = pc;
    tick();
    if_valid = 1'b0;
  endtask

  initial begin
    checks = 0;
    failures = 0;
    rst = 1'b1;
    flush = 1'b0;
    if_valid = 1'b0;
    if_inst = '0;
    if_pc = '0;
    ex_ready = 1'b1;
    ex_load_valid = 1'b0;
    ex_load_rd = 5'd0;

    tick();
    tick();
    #2 rst = 1'b0;
    #1;
    chk("rst_id_valid", {31'd0, id_valid}, 32'd0);
    chk("rst_id_inst", id_inst, 32'd0);
    chk("rst_id_pc", id_pc, 32'd0);
    chk("rst_stall", {31'd0, ld_use_stall}, 32'd0);
    chk("rst_id_ready", {31'd0, id_ready}, 32'd1);
    tick();

    // Back-to-back stream
    if_valid = 1'b1; if_inst = ADDI1; if_pc = 32'h0;
    #1;
    chk("s_empty_ready", {31'd0, id_ready}, 32'd1);
    chk("s_empty_valid", {31'd0, id_valid}, 32'd0);
    tick();
    if_inst = ADDI2; if_pc = 32'h4;
    #1;
    chk("s_c1_valid", {31'd0, id_valid}, 32'd1);
    chk("s_c1_pc", id_pc, 32'h0);
    chk("s_c1_inst", id_inst, ADDI1);
    chk("s_c1_ready", {31'd0, id_ready}, 32'd1);
    tick();
    if_valid = 1'b0;
    #1;
    chk("s_c2_valid", {31'd0, id_valid}, 32'd1);
    chk("s_c2_pc", id_pc, 32'h4);
    chk("s_c2_inst", id_inst, ADDI2);
    tick();
    chk("s_drain_valid", {31'd0, id_valid}, 32'd0);
    chk("s_drain_ready", {31'd0, id_ready}, 32'd1);

    // Load-use on rs1
    latch(ADD6, 32'h8);
    ex_load_valid = 1'b1; ex_load_rd = 5'd5;
    #1;
    chk("lu_stall", {31'd0, ld_use_stall}, 32'd1);
    chk("lu_valid", {31'd0, id_valid}, 32'd0);
    chk("lu_ready", {31'd0, id_ready}, 32'd0);
    tick();
    ex_load_valid = 1'b0;
    #1;
    chk("lu_bub_valid", {31'd0, id_valid}, 32'd0);
    chk("lu_bub_stall", {31'd0, ld_use_stall}, 32'd0);
    chk("lu_bub_inst", id_inst, ADD6);
    tick();
    chk("lu_issue_valid", {31'd0, id_valid}, 32'd1);
    chk("lu_issue_pc", id_pc, 32'h8);
    tick();
    chk("lu_done_valid", {31'd0, id_valid}, 32'd0);

    // Load-use on rs2
    latch(ADD6, 32'hC);
    ex_load_valid = 1'b1; ex_load_rd = 5'd7;
    #1;
    chk("lu2_stall", {31'd0, ld_use_stall}, 32'd1);
    tick();
    ex_load_valid = 1'b0;
    tick();
    chk("lu2_issue_valid", {31'd0, id_valid}, 32'd1);
    tick();

    // rd=0 never stalls
    latch(ADD6, 32'h10);
    ex_load_valid = 1'b1; ex_load_rd = 5'd0;
    #1;
    chk("rd0_stall", {31'd0, ld_use_stall}, 32'd0);
    chk("rd0_valid", {31'd0, id_valid}, 32'd1);
    tick();

    // LUI reads no registers
    latch(LUI5, 32'h14);
    ex_load_rd = 5'd5;
    #1;
    chk("lui_stall", {31'd0, ld_use_stall}, 32'd0);
    chk("lui_valid", {31'd0, id_valid}, 32'd1);
    tick();
    ex_load_valid = 1'b0; ex_load_rd = 5'd0;

    // CSR serialisation
    latch(CSRRW, 32'h20);
    #1;
`ifdef ID_CSR_SERIALIZE_EN
    chk("csr_w1_valid", {31'd0, id_valid}, 32'd0);
    chk("csr_w1_ready", {31'd0, id_ready}, 32'd0);
    tick();
    chk("csr_w2_valid", {31'd0, id_valid}, 32'd0);
    tick();
`endif
    chk("csr_issue_valid", {31'd0, id_valid}, 32'd1);
    chk("csr_issue_inst", id_inst, CSRRW);
    tick();
    chk("csr_done_valid", {31'd0, id_valid}, 32'd0);

    // Flush with simultaneous transfers
    latch(ADDI1, 32'h30);
    if_valid = 1'b1; if_inst = ADDI2; if_pc = 32'h34; flush = 1'b1;
    #1;
    chk("fl_ready", {31'd0, id_ready}, 32'd0);
    chk("fl_valid_pre", {31'd0, id_valid}, 32'd1);
    tick();
    flush = 1'b0; if_valid = 1'b0;
    #1;
    chk("fl_valid", {31'd0, id_valid}, 32'd0);
    chk("fl_not_latched", {31'd0, (id_pc !== 32'h34)}, 32'd1);
    chk("fl_empty_ready", {31'd0, id_ready}, 32'd1);
    tick();
    chk("fl_still_empty", {31'd0, id_valid}, 32'd0);

    // EX backpressure for 3 cycles
    latch(ADDI1, 32'h40);
    ex_ready = 1'b0; if_valid = 1'b1; if_inst = ADDI2; if_pc = 32'h44;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("bp_valid", {31'd0, id_valid}, 32'd1);
      chk("bp_pc", id_pc, 32'h40);
      chk("bp_inst", id_inst, ADDI1);
      chk("bp_ready", {31'd0, id_ready}, 32'd0);
      tick();
    end
    ex_ready = 1'b1;
    #1;
    chk("bp_rel_ready", {31'd0, id_ready}, 32'd1);
    tick();
    if_valid = 1'b0;
    #1;
    chk("bp_next_pc", id_pc, 32'h44);
    chk("bp_next_valid", {31'd0, id_valid}, 32'd1);
    tick();

    // Asynchronous reset mid-HOLD
    latch(ADDI1, 32'h50);
    ex_ready = 1'b0;
    #1;
    chk("ar_pre_valid", {31'd0, id_valid}, 32'd1);
    #2 rst = 1'b1;
    #1;
    chk("ar_valid", {31'd0, id_valid}, 32'd0);
    chk("ar_inst", id_inst, 32'd0);
    chk("ar_pc", id_pc, 32'd0);
    #2 rst = 1'b0;
    #1;
    chk("ar_ready", {31'd0, id_ready}, 32'd1);
    chk("ar_valid_post", {31'd0, id_valid}, 32'd0);
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

endmodule
